// File: rtl/s4_counter_pkg.sv
// Shared types and limits for the s4 counter slice.
package s4_counter_pkg;

  localparam int COUNT_W_MAX = 64;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    LOAD = 2'd3
  } count_mode_e;

endpackage

// File: rtl/s4_counter_next.sv
// Combinational next-count generator: wraps modulo 2^N by default; with
// S4_ACTIVIDAD2_SATURATE_EN defined it clamps at 0 and 2^N-1 instead.
module s4_counter_next
  import s4_counter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] count,
  input  logic [N-1:0] load_value,
  input  count_mode_e  mode,
  output logic [N-1:0] next_count
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic at_max;
  logic at_min;

  assign at_max = (count == {N{1'b1}});
  assign at_min = (count == {N{1'b0}});

  always_comb begin
    next_count = count;
    unique case (mode)
      LOAD: next_count = load_value;
`ifdef S4_ACTIVIDAD2_SATURATE_EN
      UP:   next_count = at_max ? count : count + ONE;
      DOWN: next_count = at_min ? count : count - ONE;
`else
      // at_max/at_min are only needed for clamping; wrap is plain N-bit math
      UP:   next_count = count + ONE;
      DOWN: next_count = count - ONE;
`endif
      HOLD: next_count = count;
      default: next_count = count;
    endcase
  end

`ifndef S4_ACTIVIDAD2_SATURATE_EN
  logic unused_flags;
  assign unused_flags = at_max ^ at_min;
`endif

endmodule

// File: rtl/s4_actividad2.sv
// N-bit up/down counter with parallel load and enable (priority reset > load > enable).
// Build option S4_ACTIVIDAD2_SATURATE_EN makes counting saturate instead of wrap.
module s4_actividad2
  import s4_counter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [N-1:0] load_value,
  input  logic         enable,
  output logic [N-1:0] counterN
);

  count_mode_e  mode;
  logic [N-1:0] next_count;

  always_comb begin
    mode = HOLD;
    if (load)        mode = LOAD;
    else if (enable) mode = dec ? DOWN : UP;
  end

  s4_counter_next #(.N(N)) u_next (
    .count      (counterN),
    .load_value (load_value),
    .mode       (mode),
    .next_count (next_count)
  );

  always_ff @(posedge clock) begin
    if (reset) counterN <= '0;
    else       counterN <= next_count;
  end

endmodule

// File: tb/tb_s4_actividad2.sv
// Scoreboard bench for s4_actividad2 at N = 64 with a priority-rule reference model.
module tb_s4_actividad2;

  localparam int N = 64;

  logic         clock;
  logic         reset;
  logic         load;
  logic         dec;
  logic         enable;
  logic [N-1:0] load_value;
  logic [N-1:0] counterN;

  s4_actividad2 #(.N(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .dec        (dec),
    .load_value (load_value),
    .enable     (enable),
    .counterN   (counterN)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] exp;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  int           compared   = 0;
  int           mismatched = 0;
  logic [N-1:0] model      = '0;

  // Reference: priority rules evaluated with wide arithmetic and carry/borrow detection.
  function automatic logic [N-1:0] ref_next(input logic [N-1:0] cur,
                                            input logic r, input logic l,
                                            input logic e, input logic d,
                                            input logic [N-1:0] lv);
    logic [N:0] wide;
    if (r)  return '0;
    if (l)  return lv;
    if (!e) return cur;
    if (!d) begin
      wide = {1'b0, cur} + 65'd1;
`ifdef S4_ACTIVIDAD2_SATURATE_EN
      if (wide[N]) return cur;
`endif
      return wide[N-1:0];
    end
`ifdef S4_ACTIVIDAD2_SATURATE_EN
    if (cur == 0) return cur;
`endif
    wide = {1'b0, cur} - 65'd1;
    return wide[N-1:0];
  endfunction

  task automatic drive(input logic r, input logic l, input logic e, input logic d,
                       input logic [N-1:0] lv, input string tag);
    exp_t item;
    @(negedge clock);
    reset      = r;
    load       = l;
    enable     = e;
    dec        = d;
    load_value = lv;
    model      = ref_next(model, r, l, e, d, lv);
    item.exp   = model;
    item.tag   = tag;
    sb.push_back(item);
  endtask

  function automatic logic [N-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Monitor: one expectation per edge, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compared++;
        if (counterN !== e.exp) begin
          mismatched++;
          $display("FAIL %s: counterN=%h expected=%h", e.tag, counterN, e.exp);
        end
      end
    end
  end

  logic [N-1:0] all_ones;
  logic [N-1:0] big;

  initial begin
    all_ones = '1;
    big      = 64'h7FFF_FFFF_FFFF_FFFF;
    reset = 1'b1; load = 1'b1; enable = 1'b1; dec = 1'b0; load_value = rand64();

    repeat (2) drive(1, 1, 1, 0, rand64(), "reset");
    repeat (3) drive(0, 0, 0, 0, rand64(), "post_reset_hold");
    repeat (100) drive(0, 0, 0, 1, rand64(), "dec_only_hold");
    repeat (5) drive(0, 0, 1, 0, rand64(), "up_count");
    repeat (3) drive(0, 0, 1, 1, rand64(), "down_count");
    drive(0, 1, 0, 0, '0, "load_zero");
    drive(0, 0, 1, 1, rand64(), "down_from_zero");
    drive(0, 1, 0, 0, all_ones, "load_max");
    drive(0, 0, 1, 0, rand64(), "up_from_max");
    repeat (4) drive(0, 1, 1, 1, big, "load_priority");
    drive(0, 1, 1, 0, rand64(), "load_tracks_value");
    repeat (7) drive(0, 0, 1, 0, rand64(), "count_before_reset");
    drive(1, 0, 1, 0, rand64(), "reset_mid_count");
    drive(0, 0, 1, 0, rand64(), "resume_after_reset");

    // Cyclic sweep over all {load, enable, dec} combinations.
    for (int m = 0; m < 8; m++) begin
      int hold_len;
      logic [N-1:0] lv;
      hold_len = $urandom_range(200, 600);
      lv = rand64();
      for (int k = 0; k < hold_len; k++) begin
        if (m[2] && (k % 50 == 0)) lv = rand64();
        drive(0, m[2], m[1], m[0], lv, $sformatf("sweep_%0d%0d%0d", m[2], m[1], m[0]));
      end
    end

    // Random mix with near-boundary loads and rare resets.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] lv;
      int sel;
      sel = $urandom_range(0, 3);
      lv  = (sel == 0) ? all_ones : (sel == 1) ? '0 : rand64();
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, lv, "random");
    end

    drive(0, 0, 0, 0, rand64(), "final_hold");
    repeat (2) @(posedge clock);
    #2;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
